wb_commit_stage: RTL and testbench

//  Parametrised writeback/commit stage of the LoongArch pipeline, after MEM. Owns its own WB pipeline register

---
 rtl/wb_commit_stage_if.sv | 25 ++
 rtl/wb_commit_stage.sv | 166 ++++++++++++++++
 tb/tb_wb_commit_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handshake and instruction bundle; MEM drives through master, WB consumes through slave.
interface wb_commit_stage_if #(
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int EXC_N     = 14,
  parameter int TLB_IDX_W = 4
);
  logic                      ms_to_ws_valid;
  logic                      ws_allowin;
  logic [2*XLEN+RF_AW+1:0]   ms_to_ws_bus;
  logic [EXC_N-1:0]          ms_excp_vec;
  logic                      ms_ertn;
  logic [14+2*XLEN:0]        ms_csr_bus;
  logic [4:0]                ms_tlb_op;
  logic [TLB_IDX_W:0]        ms_s1_bus;

  modport master (
    output ms_to_ws_valid, ms_to_ws_bus, ms_excp_vec, ms_ertn, ms_csr_bus, ms_tlb_op, ms_s1_bus,
    input  ws_allowin
  );
  modport slave (
    input  ms_to_ws_valid, ms_to_ws_bus, ms_excp_vec, ms_ertn, ms_csr_bus, ms_tlb_op, ms_s1_bus,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: WB pipeline register, exception priority encode, single-cycle commit of
// RF/CSR/TLB side effects, multi-cycle TLB stall and flush/redirect generation.
module wb_commit_stage #(
  parameter int                 XLEN        = 32,
  parameter int                 RF_AW       = 5,
  parameter int                 EXC_N       = 14,
  parameter logic [6*EXC_N-1:0] ECODE_TABLE = {EXC_N{6'h0}},
  parameter int                 TLB_IDX_W   = 4,
  parameter int                 TLB_LAT     = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  wb_commit_stage_if.slave          ms,
  input  logic [TLB_IDX_W-1:0]      tlb_rand,
  input  logic [TLB_IDX_W-1:0]      csr_tlbidx,
  input  logic [XLEN-1:0]           csr_rvalue,
  input  logic [XLEN-1:0]           ex_entry,
  output logic [RF_AW+XLEN:0]       ws_rf_bus,
  output logic [RF_AW+XLEN:0]       ws_fwd_bus,
  output logic [14+2*XLEN:0]        ws_csr_bus,
  output logic                      ws_excp,
  output logic [5:0]                ws_ecode,
  output logic                      ws_ertn,
  output logic [XLEN-1:0]           ws_vaddr,
  output logic [4+2*TLB_IDX_W:0]    ws_tlb_bus,
  output logic                      ws_flush,
  output logic [XLEN-1:0]           ws_flush_pc,
  output logic [31:0]               debug_wb_pc,
  output logic [3:0]                debug_wb_rf_we,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [31:0]               debug_wb_rf_wdata
);
  localparam int                CNT_W    = (TLB_LAT > 1) ? $clog2(TLB_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TLB_LAT - 1);

  typedef enum logic [1:0] {S_EMPTY, S_OCC, S_TLBWAIT} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*XLEN+RF_AW+1:0]   bus_q, bus_d;
  logic [EXC_N-1:0]          excp_vec_q, excp_vec_d;
  logic                      ertn_q, ertn_d;
  logic [14+2*XLEN:0]        csr_q, csr_d;
  logic [4:0]                tlb_op_q, tlb_op_d;
  logic [TLB_IDX_W:0]        s1_q, s1_d;
  logic [TLB_IDX_W-1:0]      rand_q, rand_d;

  logic [XLEN-1:0]           pc, result, rf_wdata, csr_wmask, csr_wvalue;
  logic                      rf_we, res_from_csr, csr_we, s1_found;
  logic [RF_AW-1:0]          rf_waddr;
  logic [13:0]               csr_num;
  logic                      op_srch, op_rd, op_wr, op_fill, op_inv;
  logic [TLB_IDX_W-1:0]      s1_idx, w_index;
  logic                      ws_valid, excp, tlb_pending, ready_go, commit, refetch;
  logic                      capture, rf_commit_we, tlb_ok;
  logic [5:0]                ecode;

  assign {pc, rf_we, rf_waddr, result, res_from_csr} = bus_q;
  assign {csr_we, csr_num, csr_wmask, csr_wvalue}    = csr_q;
  assign {op_srch, op_rd, op_wr, op_fill, op_inv}    = tlb_op_q;
  assign {s1_found, s1_idx}                          = s1_q;

  assign ws_valid    = (state_q != S_EMPTY);
  assign excp        = |excp_vec_q;
  assign tlb_pending = ws_valid & (|tlb_op_q) & ~excp;
  assign ready_go    = ~tlb_pending | (cnt_q == CNT_LAST);
  assign commit      = ws_valid & ready_go;
  // CRMD/ASID writes change translation context, so younger fetched instructions must be refetched.
  assign refetch     = ~excp & ~ertn_q &
                       (op_rd | op_wr | op_fill | op_inv |
                        (csr_we & ((csr_num == 14'h0) | (csr_num == 14'h18))));
  assign ws_flush    = commit & (excp | ertn_q | refetch);
  assign ms.ws_allowin = ~ws_valid | ready_go;
  assign capture     = ms.ms_to_ws_valid & ms.ws_allowin & ~ws_flush;

  // Lowest set index wins, so scan downwards and let later matches overwrite.
  always_comb begin
    ecode = 6'h0;
    for (int i = EXC_N - 1; i >= 0; i--) begin
      if (excp_vec_q[i]) ecode = ECODE_TABLE[6*i +: 6];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    excp_vec_d = excp_vec_q;
    ertn_d     = ertn_q;
    csr_d      = csr_q;
    tlb_op_d   = tlb_op_q;
    s1_d       = s1_q;
    rand_d     = rand_q;
    if (capture) begin
      state_d    = S_OCC;
      cnt_d      = '0;
      bus_d      = ms.ms_to_ws_bus;
      excp_vec_d = ms.ms_excp_vec;
      ertn_d     = ms.ms_ertn;
      csr_d      = ms.ms_csr_bus;
      tlb_op_d   = ms.ms_tlb_op;
      s1_d       = ms.ms_s1_bus;
      rand_d     = tlb_rand;
    end else begin
      case (state_q)
        S_EMPTY: state_d = S_EMPTY;
        S_OCC, S_TLBWAIT: begin
          if (ready_go) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
          end else begin
            state_d = S_TLBWAIT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      bus_q      <= '0;
      excp_vec_q <= '0;
      ertn_q     <= 1'b0;
      csr_q      <= '0;
      tlb_op_q   <= '0;
      s1_q       <= '0;
      rand_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_q      <= bus_d;
      excp_vec_q <= excp_vec_d;
      ertn_q     <= ertn_d;
      csr_q      <= csr_d;
      tlb_op_q   <= tlb_op_d;
      s1_q       <= s1_d;
      rand_q     <= rand_d;
    end
  end

  assign rf_wdata     = res_from_csr ? csr_rvalue : result;
  assign rf_commit_we = commit & rf_we & ~excp;
  assign tlb_ok       = commit & ~excp;
  assign w_index      = op_wr ? csr_tlbidx : rand_q;

  assign ws_rf_bus    = {rf_commit_we, rf_waddr, rf_wdata};
  assign ws_fwd_bus   = {ws_valid & rf_we & ~excp, rf_waddr, rf_wdata};
  assign ws_csr_bus   = {commit & csr_we & ~excp, csr_num, csr_wmask, csr_wvalue};
  assign ws_excp      = commit & excp;
  assign ws_ecode     = ecode;
  assign ws_ertn      = commit & ertn_q & ~excp;
  assign ws_vaddr     = result;
  // Top bit is reserved and always zero; fields below are LSB-aligned.
  assign ws_tlb_bus   = {1'b0, tlb_ok & (op_wr | op_fill), tlb_ok & op_rd, tlb_ok & op_srch,
                         s1_found, s1_idx, w_index};
  assign ws_flush_pc  = excp ? ex_entry : (ertn_q ? csr_rvalue : pc + XLEN'(4));

  assign debug_wb_pc       = 32'(pc);
  assign debug_wb_rf_we    = {4{rf_commit_we}};
  assign debug_wb_rf_wnum  = 5'(rf_waddr);
  assign debug_wb_rf_wdata = 32'(rf_wdata);
endmodule

// File: tb/tb_wb_commit_stage.sv
// Table-driven, scoreboard-checked bench for wb_commit_stage (TLB_LAT=3).
module tb_wb_commit_stage;
  localparam logic [83:0] ECODE_TABLE = {6'h2D, 6'h2C, 6'h2B, 6'h2A, 6'h29, 6'h28, 6'h10,
                                         6'h26, 6'h25, 6'h24, 6'h0B, 6'h22, 6'h21, 6'h20};

  logic clk = 1'b0;
  logic resetn;
  logic [3:0]  tlb_rand;
  logic [3:0]  csr_tlbidx = 4'd5;
  logic [31:0] csr_rvalue;
  logic [31:0] ex_entry = 32'h1c008000;
  logic [37:0] ws_rf_bus, ws_fwd_bus;
  logic [78:0] ws_csr_bus;
  logic        ws_excp, ws_ertn, ws_flush;
  logic [5:0]  ws_ecode;
  logic [31:0] ws_vaddr, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [12:0] ws_tlb_bus;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  wb_commit_stage_if #(.XLEN(32), .RF_AW(5), .EXC_N(14), .TLB_IDX_W(4)) mif();

  wb_commit_stage #(.XLEN(32), .RF_AW(5), .EXC_N(14), .ECODE_TABLE(ECODE_TABLE),
                    .TLB_IDX_W(4), .TLB_LAT(3)) dut (
    .clk(clk), .resetn(resetn), .ms(mif), .tlb_rand(tlb_rand), .csr_tlbidx(csr_tlbidx),
    .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .ws_rf_bus(ws_rf_bus), .ws_fwd_bus(ws_fwd_bus),
    .ws_csr_bus(ws_csr_bus), .ws_excp(ws_excp), .ws_ecode(ws_ecode), .ws_ertn(ws_ertn),
    .ws_vaddr(ws_vaddr), .ws_tlb_bus(ws_tlb_bus), .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc; logic rf_we; logic [4:0] waddr; logic [31:0] result; logic rfc;
    logic [31:0] crv; logic [13:0] evec; logic ertn; logic csr_we; logic [13:0] csr_num;
    logic [4:0] op; logic [4:0] s1; logic [3:0] rnd; int lat;
    logic e_rfwe; logic [31:0] e_wdata; logic e_excp; logic [5:0] e_ecode; logic e_ertn;
    logic e_flush; logic [31:0] e_fpc; logic e_csrwe; logic [2:0] e_tlb; logic [3:0] e_widx;
  } vec_t;
  typedef struct { int cyc; vec_t v; } sb_t;

  vec_t tbl [14];
  sb_t  sb [$];
  sb_t  mon_e;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic drive(input vec_t v);
    mif.ms_to_ws_bus = {v.pc, v.rf_we, v.waddr, v.result, v.rfc};
    mif.ms_excp_vec  = v.evec;
    mif.ms_ertn      = v.ertn;
    mif.ms_csr_bus   = {v.csr_we, v.csr_num, 32'hFFFF_FFFF, v.result};
    mif.ms_tlb_op    = v.op;
    mif.ms_s1_bus    = v.s1;
    tlb_rand         = v.rnd;
    csr_rvalue       = v.crv;
  endtask

  // Present a vector until accepted; returns the cycle its commit is expected in.
  task automatic issue(input int idx, input bit push, output int ccyc);
    vec_t v;
    int   n;
    v = tbl[idx];
    drive(v);
    mif.ms_to_ws_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mif.ws_allowin && n < 20);
    chk("accept", mif.ws_allowin, 1'b1);
    ccyc = cyc + 1 + v.lat;
    if (push) sb.push_back('{ccyc, v});
    @(posedge clk);
    #1;
    mif.ms_to_ws_valid = 1'b0;
    tlb_rand = ~v.rnd;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        $display("commit cyc=%0d pc=%h rf_we=%0b excp=%0b flush=%0b flush_pc=%h tlb=%03b",
                 cyc, mon_e.v.pc, ws_rf_bus[37], ws_excp, ws_flush, ws_flush_pc, ws_tlb_bus[11:9]);
        chk("rf_we", {ws_rf_bus[37], debug_wb_rf_we}, {mon_e.v.e_rfwe, {4{mon_e.v.e_rfwe}}});
        if (mon_e.v.e_rfwe) begin
          chk("rf_waddr", ws_rf_bus[36:32], mon_e.v.waddr);
          chk("rf_wdata", ws_rf_bus[31:0], mon_e.v.e_wdata);
          chk("dbg_pc", debug_wb_pc, mon_e.v.pc);
        end
        chk("excp", ws_excp, mon_e.v.e_excp);
        if (mon_e.v.e_excp) begin
          chk("ecode", ws_ecode, mon_e.v.e_ecode);
          chk("vaddr", ws_vaddr, mon_e.v.result);
        end
        chk("ertn", ws_ertn, mon_e.v.e_ertn);
        chk("flush", ws_flush, mon_e.v.e_flush);
        if (mon_e.v.e_flush) chk("flush_pc", ws_flush_pc, mon_e.v.e_fpc);
        chk("csr_we", ws_csr_bus[78], mon_e.v.e_csrwe);
        chk("tlb_en", ws_tlb_bus[11:9], mon_e.v.e_tlb);
        if (mon_e.v.e_tlb[2]) chk("w_index", ws_tlb_bus[3:0], mon_e.v.e_widx);
        if (mon_e.v.e_tlb[0]) chk("tlb_hit", ws_tlb_bus[8:4], mon_e.v.s1);
      end else begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
          chk("commit_missing", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
        chk("idle", {ws_rf_bus[37], ws_excp, ws_ertn, ws_flush, ws_csr_bus[78], ws_tlb_bus[11:9]}, 8'h0);
      end
    end
  end

  initial begin
    int c1, c2, c3;
    //          pc            we    wa     result        rfc   crv            evec      ertn  cwe   cnum    op        s1     rnd  lat  e_rfwe e_wdata      e_ex  e_ec   e_er  e_fl  e_fpc         e_cwe e_tlb   e_widx
    tbl[0]  = '{32'h1c000000, 1'b1, 5'd3, 32'h00000011, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b00000, 5'h00, 4'h0, 0, 1'b1, 32'h00000011, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 3'b000, 4'h0};
    tbl[1]  = '{32'h1c000004, 1'b1, 5'd4, 32'h00000022, 1'b1, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b00000, 5'h00, 4'h0, 0, 1'b1, 32'h0000abcd, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 3'b000, 4'h0};
    tbl[2]  = '{32'h1c000008, 1'b1, 5'd5, 32'h0bad0008, 1'b0, 32'h0000abcd, 14'h0088, 1'b0, 1'b1, 14'h18, 5'b00000, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b1, 6'h0b, 1'b0, 1'b1, 32'h1c008000, 1'b0, 3'b000, 4'h0};
    tbl[3]  = '{32'h1c00000c, 1'b0, 5'd0, 32'h0bad000c, 1'b0, 32'h0000abcd, 14'h2020, 1'b0, 1'b0, 14'h00, 5'b00000, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b1, 6'h25, 1'b0, 1'b1, 32'h1c008000, 1'b0, 3'b000, 4'h0};
    tbl[4]  = '{32'h1c000100, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b1, 14'h18, 5'b00000, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000104, 1'b1, 3'b000, 4'h0};
    tbl[5]  = '{32'h1c000110, 1'b1, 5'd6, 32'h00000066, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b1, 14'h05, 5'b00000, 5'h00, 4'h0, 0, 1'b1, 32'h00000066, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b1, 3'b000, 4'h0};
    tbl[6]  = '{32'h1c000200, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b1, 14'h00, 5'b00000, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000204, 1'b1, 3'b000, 4'h0};
    tbl[7]  = '{32'h1c000300, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b00100, 5'h00, 4'h2, 2, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000304, 1'b0, 3'b100, 4'h5};
    tbl[8]  = '{32'h1c000400, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b00010, 5'h00, 4'h9, 2, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000404, 1'b0, 3'b100, 4'h9};
    tbl[9]  = '{32'h1c000500, 1'b1, 5'd8, 32'h00000099, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b10000, 5'h17, 4'h0, 2, 1'b1, 32'h00000099, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 3'b001, 4'h0};
    tbl[10] = '{32'h1c000600, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b01000, 5'h00, 4'h0, 2, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000604, 1'b0, 3'b010, 4'h0};
    tbl[11] = '{32'h1c000700, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h0000abcd, 14'h0000, 1'b0, 1'b0, 14'h00, 5'b00001, 5'h00, 4'h0, 2, 1'b0, 32'h0,        1'b0, 6'h00, 1'b0, 1'b1, 32'h1c000704, 1'b0, 3'b000, 4'h0};
    tbl[12] = '{32'h1c000800, 1'b1, 5'd7, 32'h0bad0800, 1'b0, 32'h0000abcd, 14'h0002, 1'b0, 1'b0, 14'h00, 5'b00100, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b1, 6'h21, 1'b0, 1'b1, 32'h1c008000, 1'b0, 3'b000, 4'h0};
    tbl[13] = '{32'h1c000900, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h1c000800, 14'h0000, 1'b1, 1'b0, 14'h00, 5'b00000, 5'h00, 4'h0, 0, 1'b0, 32'h0,        1'b0, 6'h00, 1'b1, 1'b1, 32'h1c000800, 1'b0, 3'b000, 4'h0};

    resetn = 1'b0;
    mif.ms_to_ws_valid = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst_allowin", mif.ws_allowin, 1'b1);
    chk("rst_flush", ws_flush, 1'b0);
    chk("rst_fwd_we", ws_fwd_bus[37], 1'b0);
    chk("rst_dbg_we", debug_wb_rf_we, 4'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_on = 1'b1;

    // Single instructions with a drained pipe between them.
    for (int i = 0; i < 14; i++) begin
      issue(i, 1'b1, c1);
      for (int j = 0; j <= tbl[i].lat; j++) begin
        @(negedge clk);
        if (j == 0) chk("fwd_we", ws_fwd_bus[37], tbl[i].rf_we & (tbl[i].evec == 14'h0));
        chk("allowin_stall", mif.ws_allowin, j == tbl[i].lat);
      end
      @(posedge clk);
      #1;
    end

    // Three ALU-type instructions back-to-back commit on consecutive cycles.
    issue(0, 1'b1, c1);
    issue(1, 1'b1, c2);
    issue(0, 1'b1, c3);
    chk("b2b_gap1", c2 - c1, 1);
    chk("b2b_gap2", c3 - c2, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;

    // ertn commits while MEM offers the next instruction: that instruction is dropped.
    issue(13, 1'b1, c1);
    mif.ms_to_ws_bus   = {tbl[0].pc, tbl[0].rf_we, tbl[0].waddr, tbl[0].result, tbl[0].rfc};
    mif.ms_excp_vec    = 14'h0;
    mif.ms_ertn        = 1'b0;
    mif.ms_tlb_op      = 5'b0;
    mif.ms_to_ws_valid = 1'b1;
    @(negedge clk);
    chk("ertn_flush", ws_flush, 1'b1);
    @(posedge clk);
    #1;
    mif.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("drop_fwd_we", ws_fwd_bus[37], 1'b0);
    chk("drop_allowin", mif.ws_allowin, 1'b1);
    @(posedge clk);
    #1;

    // Reset during TLBWAIT abandons the op.
    issue(7, 1'b0, c1);
    @(negedge clk);
    @(negedge clk);
    chk("tlbwait_allowin", mif.ws_allowin, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_wait_allowin", mif.ws_allowin, 1'b1);
    chk("rst_wait_tlb_we", ws_tlb_bus[11], 1'b0);
    repeat (4) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
